vend_sequencer: RTL

//  Main transaction controller for the vending machine. Consumes debounced keypad codes and sequences

---
 rtl/vend_sequencer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: vending transaction controller (select, qty, confirm, pay, vend, change).
// Define VEND_TIMEOUT_EN to add the inactivity timeout in SELECT, QTY, CONFIRM and PAY.
module vend_sequencer #(
    parameter int          MAX_QTY     = 3,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       vend_ack,
    input  logic       coin_ack,
    output logic       vend_req,
    output logic [2:0] prod_id,
    output logic [1:0] qty,
    output logic       coin_req,
    output logic [3:0] coin_val,
    output logic [7:0] disp_value,
    output logic [2:0] disp_state,
    output logic       timeout_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        QTY     = 3'd2,
        CONFIRM = 3'd3,
        PAY     = 3'd4,
        VEND    = 3'd5,
        CHANGE  = 3'd6
    } state_t;

    localparam logic [3:0] K_OK      = 4'hF;
    localparam logic [3:0] K_CONFIRM = 4'hE;
    localparam logic [3:0] K_CANCEL  = 4'hC;

    state_t     state;
    state_t     state_n;
    logic [7:0] price;
    logic [7:0] price_n;
    logic [7:0] total;
    logic [7:0] total_n;
    logic [7:0] credit;
    logic [7:0] credit_n;
    logic [7:0] change;
    logic [7:0] change_n;
    logic [2:0] prod_n;
    logic [1:0] qty_n;
    logic       gap;
    logic       gap_n;
    logic       timeout;
    logic       pay_out;
    logic       prod_key;
    logic       qty_key;
    logic [3:0] coin_in;

    function automatic logic [7:0] price_of(input logic [3:0] k);
        logic [7:0] p;
        case (k)
            4'd1:    p = 8'd6;
            4'd2:    p = 8'd10;
            4'd3:    p = 8'd5;
            4'd4:    p = 8'd2;
            4'd5:    p = 8'd1;
            default: p = 8'd0;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] coin_amt(input logic [3:0] k);
        logic [3:0] a;
        case (k)
            4'h8:    a = 4'd1;
            4'h9:    a = 4'd5;
            4'hA:    a = 4'd10;
            default: a = 4'd0;
        endcase
        return a;
    endfunction

    // Largest coin that still fits in the remaining change.
    function automatic logic [3:0] coin_of(input logic [7:0] c);
        logic [3:0] v;
        if (c >= 8'd10) begin
            v = 4'd10;
        end else if (c >= 8'd5) begin
            v = 4'd5;
        end else begin
            v = 4'd1;
        end
        return v;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign prod_key = (key_code >= 4'd1) && (key_code <= 4'd5);
    assign qty_key  = (key_code != 4'd0) && (int'(key_code) <= MAX_QTY);
    assign coin_in  = coin_amt(key_code);

`ifdef VEND_TIMEOUT_EN
    logic [23:0] idle_cnt;
    logic        timed;

    assign timed   = (state == SELECT) || (state == QTY) ||
                     (state == CONFIRM) || (state == PAY);
    assign timeout = timed && !key_valid &&
                     (idle_cnt == TIMEOUT_CYC - 24'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (key_valid || (state_n != state)) begin
            idle_cnt <= '0;
        end else if (timed) begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        price_n  = price;
        prod_n   = prod_id;
        qty_n    = qty;
        total_n  = total;
        credit_n = credit;
        change_n = change;
        gap_n    = gap;
        case (state)
            IDLE: begin
                if (key_valid && key_code == K_OK) begin
                    state_n = SELECT;
                    price_n = 8'd0;
                    prod_n  = 3'd0;
                    qty_n   = 2'd0;
                    total_n = 8'd0;
                end
            end
            SELECT: begin
                if (key_valid) begin
                    if (prod_key) begin
                        prod_n  = key_code[2:0];
                        price_n = price_of(key_code);
                        qty_n   = 2'd1;
                        state_n = QTY;
                    end else if (key_code == K_CANCEL) begin
                        state_n = IDLE;
                    end
                end
            end
            QTY: begin
                if (key_valid) begin
                    if (qty_key) begin
                        qty_n = key_code[1:0];
                    end else if (key_code == K_OK) begin
                        total_n = price * {6'd0, qty};
                        state_n = CONFIRM;
                    end else if (key_code == K_CANCEL) begin
                        state_n = IDLE;
                    end
                end
            end
            CONFIRM: begin
                if (key_valid) begin
                    if (key_code == K_CONFIRM) begin
                        credit_n = 8'd0;
                        state_n  = PAY;
                    end else if (key_code == K_CANCEL) begin
                        state_n = IDLE;
                    end
                end
            end
            PAY: begin
                if (key_valid) begin
                    unique case (1'b1)
                        coin_in != 4'd0: credit_n = sat_add(credit, coin_in);
                        key_code == K_OK: begin
                            if (credit >= total) begin
                                state_n = VEND;
                            end
                        end
                        key_code == K_CANCEL: begin
                            change_n = credit;
                            gap_n    = 1'b0;
                            state_n  = CHANGE;
                        end
                        default: ;
                    endcase
                end
            end
            VEND: begin
                if (vend_ack) begin
                    change_n = credit - total;
                    gap_n    = 1'b0;
                    state_n  = CHANGE;
                end
            end
            CHANGE: begin
                if (change == 8'd0) begin
                    state_n = IDLE;
                end else if (gap) begin
                    gap_n = 1'b0;
                end else if (coin_ack) begin
                    change_n = change - {4'd0, coin_of(change)};
                    gap_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // An expired PAY refunds whatever was inserted; other states just abandon.
        if (timeout) begin
            if (state == PAY) begin
                change_n = credit;
                gap_n    = 1'b0;
                state_n  = CHANGE;
            end else begin
                state_n = IDLE;
            end
        end
    end

    assign pay_out = (state_n == CHANGE) && !gap_n && (change_n != 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            price      <= 8'd0;
            total      <= 8'd0;
            credit     <= 8'd0;
            change     <= 8'd0;
            gap        <= 1'b0;
            prod_id    <= 3'd0;
            qty        <= 2'd0;
            vend_req   <= 1'b0;
            coin_req   <= 1'b0;
            coin_val   <= 4'd0;
            disp_value <= 8'd0;
            disp_state <= 3'd0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_n;
            price      <= price_n;
            total      <= total_n;
            credit     <= credit_n;
            change     <= change_n;
            gap        <= gap_n;
            prod_id    <= prod_n;
            qty        <= qty_n;
            vend_req   <= (state_n == VEND);
            coin_req   <= pay_out;
            coin_val   <= pay_out ? coin_of(change_n) : 4'd0;
            disp_state <= state_n;
            timeout_o  <= timeout;
            case (state_n)
                SELECT:        disp_value <= price_n;
                QTY:           disp_value <= {6'd0, qty_n};
                CONFIRM, VEND: disp_value <= total_n;
                PAY:           disp_value <= credit_n;
                CHANGE:        disp_value <= change_n;
                default:       disp_value <= 8'd0;
            endcase
        end
    end

endmodule
